// File: rtl/wb_arbiter.sv
// Round-robin arbiter letting N_CTRL Wishbone B4 classic controllers share one
// peripheral, with one transfer per grant and a per-transfer ack timeout.
module wb_arbiter #(
    parameter int N_CTRL  = 2,
    parameter int ADR_W   = 4,
    parameter int DAT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CTRL-1:0]       ctrl_stb_i,
    input  logic [N_CTRL-1:0]       ctrl_we_i,
    input  logic [N_CTRL*ADR_W-1:0] ctrl_adr_i,
    input  logic [N_CTRL*DAT_W-1:0] ctrl_dat_i,
    output logic [DAT_W-1:0]        ctrl_dat_o,
    output logic [N_CTRL-1:0]       ctrl_ack_o,
    output logic [N_CTRL-1:0]       ctrl_err_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADR_W-1:0]        wb_adr_o,
    output logic [DAT_W-1:0]        wb_dat_o,
    input  logic [DAT_W-1:0]        wb_dat_i,
    input  logic                    wb_ack_i,
    output logic [N_CTRL-1:0]       grant_o,
    output logic [1:0]              dbg_state_o
);

    // Handshake: a controller raises stb and holds stb/we/adr/dat stable until
    // it sees its ack or err bit; the peripheral sees stb only while BUSY.
    localparam int IW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        r_state;
    logic [IW-1:0]     r_gidx;
    logic [IW-1:0]     r_last;
    logic [CW-1:0]     r_cnt;

    logic              w_busy;
    logic              w_err;
    logic              w_win_valid;
    logic [IW-1:0]     w_win_idx;
    logic [N_CTRL-1:0] w_onehot;

    // Round-robin search starting just after the last owner.
    always_comb begin
        int j;
        j           = 0;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int i = 1; i <= N_CTRL; i++) begin
            j = (i + int'(r_last)) % N_CTRL;
            if (!w_win_valid && ctrl_stb_i[IW'(j)]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IW'(j);
            end
        end
    end

    assign w_busy   = (r_state == S_BUSY);
    assign w_err    = (r_state == S_ERR);
    assign w_onehot = N_CTRL'(1) << r_gidx;

    assign wb_stb_o    = w_busy & ctrl_stb_i[r_gidx];
    assign wb_we_o     = w_busy & ctrl_we_i[r_gidx];
    assign wb_adr_o    = w_busy ? ctrl_adr_i[r_gidx*ADR_W +: ADR_W] : '0;
    assign wb_dat_o    = w_busy ? ctrl_dat_i[r_gidx*DAT_W +: DAT_W] : '0;
    assign ctrl_dat_o  = w_busy ? wb_dat_i : '0;
    assign grant_o     = w_busy ? w_onehot : '0;
    assign ctrl_ack_o  = (w_busy && wb_ack_i) ? w_onehot : '0;
    assign ctrl_err_o  = w_err ? w_onehot : '0;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_last  <= IW'(N_CTRL - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_gidx  <= w_win_idx;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ack beats abort, abort beats timeout.
                    if (wb_ack_i || !ctrl_stb_i[r_gidx]) begin
                        r_last  <= r_gidx;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt >= TO_LAST) begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    r_last  <= r_gidx;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
